pe_cluster_iact_scheduler: RTL

PE_CLUSTER_IACT_SCHEDULER -- requirements
Module: pe_cluster_iact_scheduler

---
 rtl/pe_cluster_iact_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pe_cluster_iact_scheduler.sv
// pe_cluster_iact_scheduler
// Sequences input-activation traffic from three routers through the PE-cluster
// switch. It runs either broadcast passes (one router at a time, switch in
// broadcast mode) or a unicast schedule (all routers counted in parallel).
// Optional watchdog: define PE_CLUSTER_SCHED_TIMEOUT_EN to enable it. Without
// it, timeout_err is tied low.
//
// state   | meaning
// IDLE    | waiting for start, switch in unicast mode
// BCAST   | broadcasting from router out_sel until its streams are complete
// UNICAST | every participating router streams on its own path
// DONE    | one-cycle completion pulse
module pe_cluster_iact_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_broadcast,
    input  logic [2:0] cfg_router_mask,
    input  logic [7:0] cfg_addr_len,
    input  logic [7:0] cfg_data_len,
    input  logic [2:0] rtr_addr_valid,
    input  logic [2:0] rtr_addr_ready,
    input  logic [2:0] rtr_data_valid,
    input  logic [2:0] rtr_data_ready,
    output logic       iact_data_in_sel,
    output logic [1:0] iact_data_out_sel,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_BCAST, S_UNICAST, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      mask_q;
    logic [7:0]      addr_len_q, data_len_q;
    logic [1:0]      sel_q;
    logic [2:0][7:0] addr_cnt_q, data_cnt_q;

    logic [2:0] fire_a, fire_d;
    logic [2:0] active, addr_inc, data_inc, addr_ok, data_ok, rtr_done;
    logic       pass_done, has_next, wdog_trip;
    logic [1:0] next_sel, first_sel;

    assign fire_a    = rtr_addr_valid & rtr_addr_ready;
    assign fire_d    = rtr_data_valid & rtr_data_ready;
    assign first_sel = cfg_router_mask[0] ? 2'd0 : (cfg_router_mask[1] ? 2'd1 : 2'd2);

    // Per-router counting qualifiers; counters saturate at the latched length.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            active[k]   = (state_q == S_UNICAST && mask_q[k]) ||
                          (state_q == S_BCAST && sel_q == 2'(k));
            addr_inc[k] = active[k] && fire_a[k] && (addr_cnt_q[k] != addr_len_q);
            data_inc[k] = active[k] && fire_d[k] && (data_cnt_q[k] != data_len_q);
            addr_ok[k]  = (addr_cnt_q[k] == addr_len_q) ||
                          (addr_inc[k] && (addr_cnt_q[k] + 8'd1) == addr_len_q);
            data_ok[k]  = (data_cnt_q[k] == data_len_q) ||
                          (data_inc[k] && (data_cnt_q[k] + 8'd1) == data_len_q);
            rtr_done[k] = !mask_q[k] || (addr_ok[k] && data_ok[k]);
        end
    end

    assign pass_done = addr_ok[sel_q] && data_ok[sel_q];

    // Next broadcast source: the next higher participating router, if any.
    always_comb begin
        has_next = 1'b0;
        next_sel = sel_q;
        case (sel_q)
            2'd0: begin
                if (mask_q[1]) begin
                    has_next = 1'b1;
                    next_sel = 2'd1;
                end else if (mask_q[2]) begin
                    has_next = 1'b1;
                    next_sel = 2'd2;
                end
            end
            2'd1: begin
                if (mask_q[2]) begin
                    has_next = 1'b1;
                    next_sel = 2'd2;
                end
            end
            default: ;
        endcase
    end

`ifdef PE_CLUSTER_SCHED_TIMEOUT_EN
    logic [9:0] idle_cnt_q;
    logic       tout_q;
    logic       any_counted;

    assign any_counted = |{addr_inc, data_inc};
    assign wdog_trip   = (state_q == S_BCAST || state_q == S_UNICAST) &&
                         (idle_cnt_q == 10'd1023) && !any_counted;
    assign timeout_err = tout_q;

    // Watchdog: counts busy cycles without progress; flag held until next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            tout_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            idle_cnt_q <= '0;
            if (start) tout_q <= 1'b0;
        end else if (state_q == S_BCAST || state_q == S_UNICAST) begin
            if (wdog_trip) begin
                tout_q     <= 1'b1;
                idle_cnt_q <= '0;
            end else if (any_counted) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 10'd1;
            end
        end
    end
`else
    assign wdog_trip   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!cfg_broadcast)             state_d = S_UNICAST;
                    else if (cfg_router_mask != '0) state_d = S_BCAST;
                    else                            state_d = S_DONE;
                end
            end
            S_BCAST: begin
                if (pass_done)      state_d = has_next ? S_BCAST : S_DONE;
                else if (wdog_trip) state_d = S_DONE;
            end
            S_UNICAST: begin
                if (&rtr_done || wdog_trip) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and source select.
    always_comb begin
        busy              = (state_q == S_BCAST) || (state_q == S_UNICAST);
        done              = (state_q == S_DONE);
        iact_data_in_sel  = (state_q == S_BCAST);
        iact_data_out_sel = (state_q == S_BCAST) ? sel_q : 2'd0;
    end

    // Config capture, source select and transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            addr_len_q <= '0;
            data_len_q <= '0;
            sel_q      <= '0;
            addr_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q     <= cfg_router_mask;
                        addr_len_q <= cfg_addr_len;
                        data_len_q <= cfg_data_len;
                        sel_q      <= first_sel;
                        addr_cnt_q <= '0;
                        data_cnt_q <= '0;
                    end
                end
                S_BCAST, S_UNICAST: begin
                    if (state_q == S_BCAST && pass_done) begin
                        addr_cnt_q <= '0;
                        data_cnt_q <= '0;
                        if (has_next) sel_q <= next_sel;
                    end else begin
                        for (int k = 0; k < 3; k++) begin
                            if (addr_inc[k]) addr_cnt_q[k] <= addr_cnt_q[k] + 8'd1;
                            if (data_inc[k]) data_cnt_q[k] <= data_cnt_q[k] + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
